next_pc_unit: RTL

- Next-PC generator directly upstream of the 8-bit program counter register; its `next_pc` output drives the PC register's `next_pc` input.
- Each cycle it selects the next PC from one of:
  - sequential increment
  - jump
  - conditional branch
  - call / return, with a small internal return-address stack (RAS)
  - hold (stall / halt)
- Holds halt/fault state so a stopped core keeps its PC frozen until reset.

---
 rtl/next_pc_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// Next-PC selection for an 8-bit fetch path: sequential, jump, branch, call/return
// through a small return-address stack, plus sticky halt/fault freeze until reset.
module next_pc_unit #(
  parameter int unsigned     PC_W         = 8,
  parameter int unsigned     RAS_DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PC_W-1:0]              pc,
  input  logic                         stall,
  input  logic                         ctrl_valid,
  input  logic [2:0]                   ctrl_op,
  input  logic                         cond,
  input  logic [PC_W-1:0]              target,
  output logic [PC_W-1:0]              next_pc,
  output logic                         redirect,
  output logic                         halted,
  output logic                         fault,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_count;
  logic                  r_halted;
  logic                  r_fault;
  logic [PC_W-1:0]       r_ras [RAS_DEPTH];

  logic [PC_W-1:0]       w_seq;
  logic [PC_W-1:0]       w_next_pc;
  logic                  w_redirect;
  logic                  w_push;
  logic                  w_pop;
  state_t                w_next_state;
  logic                  w_full;
  logic                  w_empty;
  logic [PTR_W-1:0]      w_wr_idx;
  logic [PTR_W-1:0]      w_top_idx;

  assign w_seq     = pc + PC_W'(1);
  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_wr_idx  = r_count[PTR_W-1:0];
  assign w_top_idx = PTR_W'(r_count - CNT_W'(1));

  // Next-PC select; stack overflow/underflow freezes the PC and faults
  always_comb begin
    w_next_pc    = w_seq;
    w_redirect   = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_next_state = r_state;
    if (reset) begin
      w_next_pc = RESET_VECTOR;
    end else if (r_state != ST_RUN || stall) begin
      w_next_pc = pc;
    end else if (ctrl_valid) begin
      case (ctrl_op)
        OP_JMP: begin
          w_next_pc  = target;
          w_redirect = 1'b1;
        end
        OP_BR: begin
          if (cond) begin
            w_next_pc  = target;
            w_redirect = 1'b1;
          end
        end
        OP_CALL: begin
          if (w_full) begin
            w_next_pc    = pc;
            w_next_state = ST_FAULT;
          end else begin
            w_next_pc  = target;
            w_redirect = 1'b1;
            w_push     = 1'b1;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_next_pc    = pc;
            w_next_state = ST_FAULT;
          end else begin
            w_next_pc  = r_ras[w_top_idx];
            w_redirect = 1'b1;
            w_pop      = 1'b1;
          end
        end
        OP_HALT: begin
          w_next_pc    = pc;
          w_next_state = ST_HALT;
        end
        default: w_next_pc = w_seq;
      endcase
    end
  end

  // Control state, stack depth and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_count  <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state != ST_RUN);
      r_fault  <= r_fault | (w_next_state == ST_FAULT);
      if (w_push) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Stack storage needs no reset; w_push is already low while reset is high
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[w_wr_idx] <= w_seq;
    end
  end

  assign next_pc   = w_next_pc;
  assign redirect  = w_redirect;
  assign halted    = r_halted;
  assign fault     = r_fault;
  assign ras_count = r_count;

endmodule
